// File: rtl/rf_arb_pkg.sv
// Shared sizing defaults and FSM state encoding for the register-file port arbiter.
package rf_arb_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = $clog2(NREGS);

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_HALT_WAIT = 3'd2,
    ST_ACCESS    = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Bundle of pipeline writeback, register-file port and debug-loader signals around the arbiter.
interface regfile_port_arbiter_if #(
  parameter int unsigned XLEN  = rf_arb_pkg::XLEN,
  parameter int unsigned NREGS = rf_arb_pkg::NREGS
);
  localparam int unsigned AW = $clog2(NREGS);

  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [AW-1:0]   core_rs1;
  logic            core_halted;
  logic            stall_req;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [AW-1:0]   rf_rs1;
  logic [XLEN-1:0] rf_rs1_data;
  logic            dbg_req;
  logic            dbg_we;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_wdata;
  logic            dbg_ack;
  logic [XLEN-1:0] dbg_rdata;
  logic            init_done;

  modport slave (
    input  wb_we, wb_rd, wb_data, core_rs1, core_halted, rf_rs1_data,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output stall_req, rf_we, rf_rd, rf_wdata, rf_rs1, dbg_ack, dbg_rdata, init_done
  );

  modport master (
    output wb_we, wb_rd, wb_data, core_rs1, core_halted, rf_rs1_data,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  stall_req, rf_we, rf_rd, rf_wdata, rf_rs1, dbg_ack, dbg_rdata, init_done
  );

endinterface

// File: rtl/regfile_port_arbiter.sv
// Shares the register-file write/rs1 ports between the core pipeline and a debug loader,
// clearing x1..x(NREGS-1) after reset and halting the core around each debug access.
module regfile_port_arbiter #(
  parameter int unsigned XLEN  = rf_arb_pkg::XLEN,
  parameter int unsigned NREGS = rf_arb_pkg::NREGS
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_port_arbiter_if.slave bus
);
  import rf_arb_pkg::*;

  localparam int unsigned     AW       = $clog2(NREGS);
  localparam logic [AW-1:0]   LAST_REG = AW'(NREGS - 1);
  localparam logic [AW-1:0]   X0       = '0;

  localparam logic [2:0] S_INIT      = 3'(ST_INIT);
  localparam logic [2:0] S_IDLE      = 3'(ST_IDLE);
  localparam logic [2:0] S_HALT_WAIT = 3'(ST_HALT_WAIT);
  localparam logic [2:0] S_ACCESS    = 3'(ST_ACCESS);
  localparam logic [2:0] S_RESP      = 3'(ST_RESP);

  logic [2:0]      state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            init_done_q;
  logic [XLEN-1:0] rdata_q;

  logic            we_c;
  logic [AW-1:0]   rd_c;
  logic [XLEN-1:0] wdata_c;
  logic [AW-1:0]   rs1_c;
  logic            stall_c;
  logic            ack_c;
  logic            rload_c;

  // State, clear counter and debug read-data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      cnt_q       <= AW'(1);
      init_done_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_INIT && cnt_q == LAST_REG) init_done_q <= 1'b1;
      if (rload_c) rdata_q <= (bus.dbg_addr == X0) ? '0 : bus.rf_rs1_data;
    end
  end

  // Next state plus write-port and rs1 muxes; writeback passes through unless overridden
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_c    = bus.wb_we;
    rd_c    = bus.wb_rd;
    wdata_c = bus.wb_data;
    rs1_c   = bus.core_rs1;
    stall_c = 1'b1;
    ack_c   = 1'b0;
    rload_c = 1'b0;
    case (state_q)
      S_INIT: begin
        we_c    = 1'b1;
        rd_c    = cnt_q;
        wdata_c = '0;
        if (cnt_q == LAST_REG) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + AW'(1);
      end
      S_IDLE: begin
        stall_c = 1'b0;
        if (bus.dbg_req) state_d = S_HALT_WAIT;
      end
      S_HALT_WAIT: begin
        if (bus.core_halted) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        rs1_c = bus.dbg_addr;
        // A writeback in flight wins; the debug access retries next cycle
        if (!bus.wb_we) begin
          if (bus.dbg_we) begin
            we_c    = 1'b1;
            rd_c    = bus.dbg_addr;
            wdata_c = bus.dbg_wdata;
          end else begin
            rload_c = 1'b1;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        stall_c = 1'b0;
        ack_c   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = AW'(1);
      end
    endcase
  end

  // x0 is hardwired, so no write to it ever reaches the register file
  assign bus.rf_we     = we_c & (rd_c != X0) & ~rst;
  assign bus.rf_rd     = rd_c;
  assign bus.rf_wdata  = wdata_c;
  assign bus.rf_rs1    = rs1_c;
  assign bus.stall_req = stall_c;
  assign bus.dbg_ack   = ack_c;
  assign bus.dbg_rdata = rdata_q;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: directed vectors, corner sequences and a random run.
module tb_regfile_port_arbiter;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  always #5 clk = ~clk;

  regfile_port_arbiter_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();
  regfile_port_arbiter #(.XLEN(XLEN), .NREGS(NREGS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] phys [NREGS];
  logic [XLEN-1:0] gold [NREGS];
  logic            use_model;
  logic [XLEN-1:0] rs1_drive;
  logic            prev_stall;

  // Register file stand-in: captures whatever the DUT writes, serves rs1 reads
  assign bus.rf_rs1_data = use_model ? phys[bus.rf_rs1] : rs1_drive;
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(NREGS); i++) phys[i] <= '0;
    end else if (!rst && bus.rf_we) begin
      phys[bus.rf_rd] <= bus.rf_wdata;
    end
  end

  typedef struct {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rs1data;
    logic            exp_rf_we;
    logic [XLEN-1:0] exp_rdata;
    int              exp_ack_cyc;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One random-phase cycle: debug fields as given, random writeback traffic and core halting
  task automatic rnd_cycle(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [XLEN-1:0] data, output logic ack, output logic [XLEN-1:0] rdata);
    @(posedge clk); #1;
    bus.dbg_req   = req;
    bus.dbg_we    = we;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = data;
    bus.wb_we     = ($urandom % 3) == 0;
    bus.wb_rd     = (($urandom % 8) == 0) ? '0 : AW'(16 + ($urandom % 16));
    bus.wb_data   = $urandom;
    bus.core_rs1  = AW'($urandom);
    bus.core_halted = prev_stall && (($urandom % 2) == 1);
    if (bus.wb_we && bus.wb_rd != 0) gold[bus.wb_rd] = bus.wb_data;
    #2;
    if (bus.wb_we && bus.wb_rd != 0) begin
      chk("rnd_wb_we", XLEN'(bus.rf_we), 1);
      chk("rnd_wb_rd", XLEN'(bus.rf_rd), XLEN'(bus.wb_rd));
      chk("rnd_wb_data", bus.rf_wdata, bus.wb_data);
    end
    if (bus.rf_we) chk("rnd_rd_nonzero", XLEN'(bus.rf_rd != 0), 1);
    prev_stall = bus.stall_req;
    ack   = bus.dbg_ack;
    rdata = bus.dbg_rdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ack_cyc, ack_n, we_cyc, done_cyc, early_ack;
    logic stall0, stall1, stall_ack, we_seen, acked;
    logic [AW-1:0] rs1_2, we_rd;
    logic [XLEN-1:0] we_data, rdata_ack;
    logic [XLEN-1:0] cyc_we [8];
    logic [AW-1:0]   cyc_rd [8];
    logic [XLEN-1:0] cyc_wd [8];

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 32'h0,        1'b1, 32'h0,        3};
    vecs[1] = '{1'b0, 5'd5,  32'h0,        32'h12345678, 1'b0, 32'h12345678, 3};
    vecs[2] = '{1'b1, 5'd0,  32'hCAFEF00D, 32'h0,        1'b0, 32'h12345678, 3};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        32'hFFFFFFFF, 1'b0, 32'h0,        3};
    vecs[4] = '{1'b1, 5'd31, 32'h0BADC0DE, 32'h0,        1'b1, 32'h0,        3};
    vecs[5] = '{1'b0, 5'd31, 32'h0,        32'hA5A55A5A, 1'b0, 32'hA5A55A5A, 3};

    use_model = 1'b0; rs1_drive = '0; prev_stall = 1'b0;
    bus.wb_we = 0; bus.wb_rd = '0; bus.wb_data = '0; bus.core_rs1 = '0; bus.core_halted = 0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    clr = 1'b1; rst = 1'b1;
    #2;
    chk("rst_stall", XLEN'(bus.stall_req), 1);
    chk("rst_init_done", XLEN'(bus.init_done), 0);
    chk("rst_ack", XLEN'(bus.dbg_ack), 0);
    chk("rst_rdata", bus.dbg_rdata, 0);
    chk("rst_rf_we", XLEN'(bus.rf_we), 0);
    @(posedge clk); @(posedge clk); #1;
    clr = 1'b0; rst = 1'b0;
    #2;

    // Register clear after reset release
    for (int i = 1; i < int'(NREGS); i++) begin
      if (i > 1) begin @(posedge clk); #3; end
      chk("init_we", XLEN'(bus.rf_we), 1);
      chk("init_rd", XLEN'(bus.rf_rd), XLEN'(i));
      chk("init_wdata", bus.rf_wdata, 0);
      chk("init_stall", XLEN'(bus.stall_req), 1);
      chk("init_done_low", XLEN'(bus.init_done), 0);
    end
    @(posedge clk); #3;
    chk("init_done_high", XLEN'(bus.init_done), 1);
    chk("idle_stall", XLEN'(bus.stall_req), 0);
    bus.core_halted = 1'b1;

    // Directed debug accesses with the core already halted
    for (int v = 0; v < 6; v++) begin
      ack_cyc = -1; ack_n = 0; we_cyc = -1; we_seen = 0; acked = 0;
      stall0 = 0; stall1 = 0; stall_ack = 1; rs1_2 = '0; we_rd = '0; we_data = '0; rdata_ack = '0;
      for (int c = 0; c < 7; c++) begin
        @(posedge clk); #1;
        if (c == 0) begin
          bus.dbg_req = 1; bus.dbg_we = vecs[v].we; bus.dbg_addr = vecs[v].addr;
          bus.dbg_wdata = vecs[v].wdata; rs1_drive = vecs[v].rs1data;
        end
        if (acked) bus.dbg_req = 0;
        #2;
        if (c == 0) stall0 = bus.stall_req;
        if (c == 1) stall1 = bus.stall_req;
        if (c == 2) rs1_2 = bus.rf_rs1;
        if (bus.rf_we && !we_seen) begin
          we_seen = 1; we_cyc = c; we_rd = bus.rf_rd; we_data = bus.rf_wdata;
        end
        if (bus.dbg_ack) begin
          ack_n++;
          if (ack_cyc < 0) begin
            ack_cyc = c; rdata_ack = bus.dbg_rdata; stall_ack = bus.stall_req; acked = 1;
          end
        end
      end
      chk("vec_ack_cycle", XLEN'(ack_cyc), XLEN'(vecs[v].exp_ack_cyc));
      chk("vec_ack_count", XLEN'(ack_n), 1);
      chk("vec_stall_c0", XLEN'(stall0), 0);
      chk("vec_stall_c1", XLEN'(stall1), 1);
      chk("vec_stall_ack", XLEN'(stall_ack), 0);
      chk("vec_access_rs1", XLEN'(rs1_2), XLEN'(vecs[v].addr));
      chk("vec_rf_we", XLEN'(we_seen), XLEN'(vecs[v].exp_rf_we));
      if (vecs[v].exp_rf_we) begin
        chk("vec_we_cycle", XLEN'(we_cyc), 2);
        chk("vec_we_rd", XLEN'(we_rd), XLEN'(vecs[v].addr));
        chk("vec_we_data", we_data, vecs[v].wdata);
      end
      chk("vec_rdata", rdata_ack, vecs[v].exp_rdata);
    end

    // Writeback collides with the first ACCESS cycle
    ack_cyc = -1; acked = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 5'd9; bus.dbg_wdata = 32'h600DF00D;
      end
      bus.wb_we = (c == 2); bus.wb_rd = 5'd7; bus.wb_data = 32'h77770007;
      if (acked) bus.dbg_req = 0;
      #2;
      cyc_we[c] = XLEN'(bus.rf_we); cyc_rd[c] = bus.rf_rd; cyc_wd[c] = bus.rf_wdata;
      if (bus.dbg_ack && ack_cyc < 0) begin ack_cyc = c; acked = 1; end
    end
    bus.wb_we = 0;
    chk("col_wb_we", cyc_we[2], 1);
    chk("col_wb_rd", XLEN'(cyc_rd[2]), 7);
    chk("col_wb_data", cyc_wd[2], 32'h77770007);
    chk("col_dbg_we", cyc_we[3], 1);
    chk("col_dbg_rd", XLEN'(cyc_rd[3]), 9);
    chk("col_dbg_data", cyc_wd[3], 32'h600DF00D);
    chk("col_ack_cycle", XLEN'(ack_cyc), 4);

    // Reset during HALT_WAIT; request held through the new clear
    @(posedge clk); #1;
    bus.core_halted = 0; bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 5'd3; rs1_drive = 32'h33333333;
    #2;
    chk("rhw_stall_c0", XLEN'(bus.stall_req), 0);
    @(posedge clk); #3;
    chk("rhw_stall_c1", XLEN'(bus.stall_req), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rhw_rst_stall", XLEN'(bus.stall_req), 1);
    chk("rhw_rst_ack", XLEN'(bus.dbg_ack), 0);
    chk("rhw_rst_rf_we", XLEN'(bus.rf_we), 0);
    chk("rhw_rst_init_done", XLEN'(bus.init_done), 0);
    chk("rhw_rst_rdata", bus.dbg_rdata, 0);
    bus.core_halted = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    chk("rhw_restart_we", XLEN'(bus.rf_we), 1);
    chk("rhw_restart_rd", XLEN'(bus.rf_rd), 1);
    done_cyc = -1; ack_cyc = -1; early_ack = 0; ack_n = 0; acked = 0; rdata_ack = '0;
    for (int k = 1; k < 50; k++) begin
      @(posedge clk); #1;
      if (acked) bus.dbg_req = 0;
      #2;
      if (bus.init_done && done_cyc < 0) done_cyc = k;
      if (bus.dbg_ack) begin
        ack_n++;
        if (done_cyc < 0) early_ack++;
        else if (ack_cyc < 0) begin ack_cyc = k; rdata_ack = bus.dbg_rdata; acked = 1; end
      end
    end
    chk("rhw_done_cycle", XLEN'(done_cyc), 31);
    chk("rhw_early_ack", XLEN'(early_ack), 0);
    chk("rhw_ack_latency", XLEN'(ack_cyc - done_cyc), 3);
    chk("rhw_ack_count", XLEN'(ack_n), 1);
    chk("rhw_rdata", rdata_ack, 32'h33333333);

    // Random traffic against a register-content model (debug x0..x15, writeback x16..x31)
    use_model = 1'b1;
    for (int i = 0; i < int'(NREGS); i++) gold[i] = '0;
    for (int t = 0; t < 40; t++) begin
      logic            twe, ack;
      logic [AW-1:0]   taddr;
      logic [XLEN-1:0] tdata, texp, rd;
      int              n;
      twe   = ($urandom % 2) == 1;
      taddr = AW'($urandom % 16);
      tdata = $urandom;
      texp  = (taddr == 0) ? '0 : gold[taddr];
      if (twe && taddr != 0) gold[taddr] = tdata;
      ack = 0; n = 0; rd = '0;
      while (!ack && n < 60) begin
        rnd_cycle(1'b1, twe, taddr, tdata, ack, rd);
        n++;
      end
      chk("rnd_ack", XLEN'(ack), 1);
      if (ack && !twe) chk("rnd_rdata", rd, texp);
      rnd_cycle(1'b0, twe, taddr, tdata, ack, rd);
      chk("rnd_ack_pulse", XLEN'(ack), 0);
      for (int g = 0; g < int'($urandom % 3); g++) rnd_cycle(1'b0, 1'b0, '0, '0, ack, rd);
    end
    @(posedge clk); #1;
    bus.wb_we = 0; bus.dbg_req = 0;
    @(posedge clk); #3;
    for (int i = 0; i < int'(NREGS); i++) chk("final_reg", phys[i], gold[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
